// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: shared widths and pipeline stage records for the MAC-sharing controller
package cnn_mac_pkg;
  localparam int A_W = 14;
  localparam int B_W = 8;
  localparam int P_W = 22;
  localparam int ACC_W_DEF = 32;
  localparam int ID_MAX_W = 3;
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic last;
    logic [ID_MAX_W-1:0] id;
  } s1_t;
  typedef struct packed {
    logic [P_W-1:0] p;
    logic last;
    logic [ID_MAX_W-1:0] id;
  } s2_t;
endpackage

// File: rtl/cnn_mac_share_ctrl_if.sv
// cnn_mac_share_ctrl_if: per-lane beat streams in, one backpressured result stream out
interface cnn_mac_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int ACC_W = 32
);
  logic [NUM_REQ-1:0] in_valid;
  logic [NUM_REQ-1:0] in_ready;
  logic [NUM_REQ*14-1:0] in_a;
  logic [NUM_REQ*8-1:0] in_b;
  logic [NUM_REQ-1:0] in_last;
  logic res_valid;
  logic res_ready;
  logic [ACC_W-1:0] res_data;
  logic [ID_W-1:0] res_id;
  logic busy;
  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input in_ready, res_valid, res_data, res_id, busy
  );
  modport slave (
    input in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/cnn_mac_rr_arb.sv
// cnn_mac_rr_arb: round-robin grant searching upward from the last winner
module cnn_mac_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  input logic [NUM_REQ-1:0] req,
  input logic en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0] gid,
  output logic any
);
  logic [ID_W-1:0] ptr;
  always_comb begin
    gid = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!any && req[ID_W'((int'(ptr) + k) % NUM_REQ)]) begin
        any = 1'b1;
        gid = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    grant = any ? NUM_REQ'(1) << gid : '0;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= ID_W'(NUM_REQ - 1);
    else if (en && any) ptr <= gid;
endmodule

// File: rtl/cnn_mul_mul_14s_8g8j.sv
// cnn_mul_mul_14s_8g8j: 14-bit signed by 8-bit unsigned multiplier, 22-bit product
module cnn_mul_mul_14s_8g8j
  import cnn_mac_pkg::*;
(
  input logic [A_W-1:0] din0,
  input logic [B_W-1:0] din1,
  output logic [P_W-1:0] dout
);
  assign dout = $signed({{(P_W-A_W){din0[A_W-1]}}, din0}) * $signed({{(P_W-B_W){1'b0}}, din1});
endmodule

// File: rtl/cnn_mac_share_ctrl.sv
// cnn_mac_share_ctrl: shares one multiplier across lanes, per-lane accumulators, one result port
module cnn_mac_share_ctrl
  import cnn_mac_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic ap_clk,
  input logic ap_rst,
  cnn_mac_share_ctrl_if.slave bus
);
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] gid, sid;
  logic any, stall, hs, v1, v2;
  s1_t s1;
  s2_t s2;
  logic [P_W-1:0] prod;
  logic [ACC_W-1:0] acc [NUM_REQ];
  logic [ACC_W-1:0] sum;
  assign stall = bus.res_valid & ~bus.res_ready;
  assign hs = any & ~stall & ~ap_rst;
  assign bus.in_ready = hs ? grant : '0;
  assign bus.busy = v1 | v2 | bus.res_valid;
  assign sid = ID_W'(s2.id);
  assign sum = acc[sid] + {{(ACC_W-P_W){s2.p[P_W-1]}}, s2.p};
  cnn_mac_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk(ap_clk), .rst(ap_rst), .req(bus.in_valid), .en(~stall), .grant(grant), .gid(gid), .any(any)
  );
  cnn_mul_mul_14s_8g8j u_mul (.din0(s1.a), .din1(s1.b), .dout(prod));
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_id <= '0;
    end else if (!stall) begin
      v1 <= hs;
      if (hs)
        s1 <= '{a: bus.in_a[int'(gid)*A_W +: A_W], b: bus.in_b[int'(gid)*B_W +: B_W],
                last: bus.in_last[gid], id: ID_MAX_W'(gid)};
      v2 <= v1;
      s2 <= '{p: prod, last: s1.last, id: s1.id};
      bus.res_valid <= v2 & s2.last;
      if (v2 && s2.last) begin
        bus.res_data <= sum;
        bus.res_id <= sid;
        acc[sid] <= '0;
      end else if (v2) acc[sid] <= sum;
    end
endmodule

// File: doc/cnn_mac_share_ctrl.md
# cnn_mac_share_ctrl

Time-multiplexed MAC controller that shares one 14-bit-signed × 8-bit-unsigned DSP multiplier among NUM_REQ convolution lanes. Each lane streams (activation, weight) beats with a last flag. The block arbitrates round-robin, pipelines each beat through the shared multiplier, and keeps one accumulator per lane. When a lane's last beat completes, it emits that lane's dot-product result through a single backpressured result port. It sits between the per-channel window generators and the CNN output/bias stage.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting lanes (2..8)
- ID_W, 2: width of lane index, equal to clog2(NUM_REQ)
- ACC_W, 32: accumulator/result width (≥ 22)

Ports:
- ap_clk  in  1  single clock; all logic on the rising edge
- ap_rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_REQ  per-lane beat valid
- in_ready  out  NUM_REQ  per-lane beat accept; one-hot or zero
- in_a  in  NUM_REQ*14  per-lane activation, signed; lane i at bits [14i+13:14i]
- in_b  in  NUM_REQ*8  per-lane weight, unsigned; lane i at bits [8i+7:8i]
- in_last  in  NUM_REQ  per-lane marker for the final beat of a dot product
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- res_data  out  ACC_W  signed dot-product result
- res_id  out  ID_W  lane that produced res_data
- busy  out  1  any pipeline stage valid or res_valid

## Operation
- Arbiter:
  - Round-robin over in_valid, searching from rr_ptr+1 upward with wrap.
  - grant is combinational. in_ready[g] = grant[g] & ~stall.
  - rr_ptr updates to g only on a handshake (in_valid[g] & in_ready[g]).
  - A lane with no valid beat is skipped in the same cycle, with no idle slot.
- Pipeline, all stages advancing together when ~stall:
  - S1 registers a, b, last, id and v1 on handshake. v1 = 0 otherwise.
  - S2 registers product p = $signed(a) * $signed({1'b0,b}), 22 bits, from the shared multiplier, plus last, id and v2.
  - S3 (accumulate):
    - If v2 and not last: acc[id] <= acc[id] + sext(p).
    - If v2 and last: res_data <= acc[id] + sext(p), res_id <= id, res_valid <= 1, acc[id] <= 0.
- Arithmetic:
  - Two's-complement, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W, with no saturation.
- stall = res_valid & ~res_ready. Stall freezes S1, S2, the accumulators and rr_ptr, and drives in_ready to 0.
- res_valid clears on res_valid & res_ready unless a new last result loads in the same edge; in that case it stays 1 with the new data.
- Lanes may interleave freely. Each accumulator is independent; beats of one lane stay in order.
- A single beat with last = 1 produces a·b directly.

## Timing
- Reset values:
  - in_ready = 0 during reset.
  - res_valid = 0, res_data = 0, res_id = 0, busy = 0.
  - v1 = v2 = 0, all acc = 0, rr_ptr = NUM_REQ−1, so lane 0 wins first.
- Latency: the handshake at edge E0 makes res_valid = 1 after edge E2, i.e. 3 cycles.
- Throughput: 1 beat/cycle aggregate with no stall. Each of K continuously-valid lanes gets 1 beat every K cycles.
- Simultaneous events:
  - A last for lane j arriving in S3 while res_valid is held by a consumer not ready is prevented by the stall. No result is ever overwritten or dropped.
  - A handshake and an rr_ptr update in the same cycle as a res accept are legal.
- Reset mid-operation discards all in-flight beats and partial sums. The next result reflects only post-reset beats.
- in_ready stays combinational from in_valid, rr_ptr and stall. No other comb path from inputs to outputs.

## Structure
- Package cnn_mac_pkg:
  - A_W = 14, B_W = 8, P_W = 22.
  - Default ACC_W.
  - Stage record typedefs (s1_t: a, b, last, id; s2_t: p, last, id).
- Sub-module cnn_mac_rr_arb: NUM_REQ-wide round-robin grant with pointer, enable = handshake.
- Multiply with the existing cnn_mul_mul_14s_8g8j instance (din0 = a, din1 = b, dout = 22 bits), registered by S2.

## Test plan
- Single lane 0: beats (a = 3, b = 4), (a = −5, b = 2), then (a = 7, b = 1, last) → res_data = 9, res_id = 0, 3 cycles after the last handshake.
- Corner product: a = −8192, b = 255, last → res_data = −2088960 sign-extended. a = 8191, b = 255 → 2088705.
- All 4 lanes valid continuously → grants cycle 0, 1, 2, 3, 0, … One in_ready high per cycle. Each lane's sums are correct and independent.
- res_ready held 0 with a result pending, while lane 1 streams → in_ready = 0 and the pipeline freezes. Releasing res_ready delivers the pending result, then lane 1's result, with none lost.
- ap_rst pulsed for 1 cycle mid-stream on lane 2 → outputs take reset values. A following sequence (a = 1, b = 1, last) gives 1, not the stale sum.
- Wrap: ACC_W = 22, accumulate 3 × (8191·255) → result 6266115 wrapped modulo 2^22 = 2071811.
